// File: rtl/axi_lite_arbiter_n_if.sv
// ---------------------------------------------------------------------------
// axi_lite_if
// AXI4-Lite bundle between the arbiter and the shared slave port.
//   master modport : drives AR/AW/W channels and R/B ready
//   slave  modport : drives the ready of AR/AW/W and the R/B channels
// Parameters: ADDR_W (address width), DATA_W (data width, strobe = DATA_W/8).
// ---------------------------------------------------------------------------
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wmask;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arbiter_n.sv
// ---------------------------------------------------------------------------
// axi_lite_arbiter_n
// N-master to 1-slave AXI4-Lite arbiter with independent read and write paths.
// Each path registers a grant (round-robin or fixed priority), locks onto the
// granted master for one full transaction, then returns to IDLE.
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   m_ar* / m_r*         : per-master read address / read data channels
//   m_aw* / m_w* / m_b*  : per-master write address / data / response channels
//   s                    : downstream AXI4-Lite slave port (master modport)
//   rd_gnt, wr_gnt       : currently granted master per path (debug)
//   rd_busy, wr_busy     : path not in IDLE
//   rd_state, wr_state   : raw FSM state per path (debug)
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high. valid never waits on ready; once raised, valid and
// its payload are held until the transfer. Ready may depend combinationally on
// valid. The arbiter adds no storage: ready/valid are steered through to and
// from the granted master only.
// ---------------------------------------------------------------------------
module axi_lite_arbiter_n #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_EN     = 1,
  localparam int GW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset,
  // read address / data
  input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
  input  logic [N_MASTERS-1:0]          m_arvalid,
  output logic [N_MASTERS-1:0]          m_arready,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [N_MASTERS*2-1:0]        m_rresp,
  output logic [N_MASTERS-1:0]          m_rvalid,
  input  logic [N_MASTERS-1:0]          m_rready,
  // write address / data / response
  input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
  input  logic [N_MASTERS-1:0]          m_awvalid,
  output logic [N_MASTERS-1:0]          m_awready,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*STRB_W-1:0]   m_wmask,
  input  logic [N_MASTERS-1:0]          m_wvalid,
  output logic [N_MASTERS-1:0]          m_wready,
  output logic [N_MASTERS*2-1:0]        m_bresp,
  output logic [N_MASTERS-1:0]          m_bvalid,
  input  logic [N_MASTERS-1:0]          m_bready,
  // downstream slave
  axi_lite_if.master                    s,
  // debug / status
  output logic [GW-1:0]                 rd_gnt,
  output logic [GW-1:0]                 wr_gnt,
  output logic                          rd_busy,
  output logic                          wr_busy,
  output logic [1:0]                    rd_state,
  output logic [1:0]                    wr_state
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} wr_state_e;

  // Pointer reset value makes master 0 the first round-robin winner.
  localparam logic [GW-1:0] LAST_RST = GW'(N_MASTERS - 1);

  // Winner selection. Round-robin scans cyclically starting one past the
  // previous winner; fixed priority scans from index 0.
  function automatic logic [GW-1:0] pick(input logic [N_MASTERS-1:0] req,
                                         input logic [GW-1:0]        last);
    logic [GW-1:0] win;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (RR_EN != 0) idx = (int'(last) + 1 + k) % N_MASTERS;
      else            idx = k;
      if (!found && req[idx]) begin
        win   = idx[GW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  rd_state_e     rd_state_q, rd_state_d;
  logic [GW-1:0] rd_gnt_q, rd_gnt_d;
  logic [GW-1:0] rd_last_q, rd_last_d;
  logic          s_arvalid, s_rready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      rd_gnt_q   <= '0;
      rd_last_q  <= LAST_RST;
    end else begin
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_last_q  <= rd_last_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_last_d  = rd_last_q;
    case (rd_state_q)
      R_IDLE: begin
        if (|m_arvalid) begin
          rd_gnt_d   = pick(m_arvalid, rd_last_q);
          rd_last_d  = rd_gnt_d;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR:  if (s_arvalid && s.arready) rd_state_d = R_DATA;
      R_DATA:  if (s.rvalid && s_rready)   rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    case (rd_state_q)
      R_ADDR: begin
        s_arvalid           = m_arvalid[rd_gnt_q];
        m_arready[rd_gnt_q] = s.arready;
      end
      R_DATA: begin
        s_rready           = m_rready[rd_gnt_q];
        m_rvalid[rd_gnt_q] = s.rvalid;
      end
      default: ;
    endcase
  end

  assign s.arvalid = s_arvalid;
  assign s.rready  = s_rready;
  assign s.araddr  = m_araddr[rd_gnt_q*ADDR_W +: ADDR_W];
  assign m_rdata   = {N_MASTERS{s.rdata}};
  assign m_rresp   = {N_MASTERS{s.rresp}};

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  wr_state_e     wr_state_q, wr_state_d;
  logic [GW-1:0] wr_gnt_q, wr_gnt_d;
  logic [GW-1:0] wr_last_q, wr_last_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          s_awvalid, s_wvalid, s_bready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      wr_gnt_q   <= '0;
      wr_last_q  <= LAST_RST;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_last_d  = wr_last_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      W_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        // A master may lead with either AW or W, so both count as a request.
        if (|(m_awvalid | m_wvalid)) begin
          wr_gnt_d   = pick(m_awvalid | m_wvalid, wr_last_q);
          wr_last_d  = wr_gnt_d;
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        aw_done_d = aw_done_q | (s_awvalid & s.awready);
        w_done_d  = w_done_q  | (s_wvalid  & s.wready);
        // Includes a handshake completing this very cycle.
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP:  if (s.bvalid && s_bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    case (wr_state_q)
      W_ADDR: begin
        // Each channel is forwarded only until its own handshake completes.
        if (!aw_done_q) begin
          s_awvalid           = m_awvalid[wr_gnt_q];
          m_awready[wr_gnt_q] = s.awready;
        end
        if (!w_done_q) begin
          s_wvalid           = m_wvalid[wr_gnt_q];
          m_wready[wr_gnt_q] = s.wready;
        end
      end
      W_RESP: begin
        s_bready           = m_bready[wr_gnt_q];
        m_bvalid[wr_gnt_q] = s.bvalid;
      end
      default: ;
    endcase
  end

  assign s.awvalid = s_awvalid;
  assign s.wvalid  = s_wvalid;
  assign s.bready  = s_bready;
  assign s.awaddr  = m_awaddr[wr_gnt_q*ADDR_W +: ADDR_W];
  assign s.wdata   = m_wdata[wr_gnt_q*DATA_W +: DATA_W];
  assign s.wmask   = m_wmask[wr_gnt_q*STRB_W +: STRB_W];
  assign m_bresp   = {N_MASTERS{s.bresp}};

  // -------------------------------------------------------------------------
  // Status
  // -------------------------------------------------------------------------
  assign rd_gnt   = rd_gnt_q;
  assign wr_gnt   = wr_gnt_q;
  assign rd_busy  = (rd_state_q != R_IDLE);
  assign wr_busy  = (wr_state_q != W_IDLE);
  assign rd_state = rd_state_q;
  assign wr_state = wr_state_q;

endmodule

// File: tb/tb_axi_lite_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_arbiter_n
// Directed bench for axi_lite_arbiter_n with three masters. One instance runs
// round-robin against a behavioural slave, a second runs fixed priority
// against an always-ready slave. Expected handshakes are queued by the
// stimulus and popped by a monitor whenever a handshake appears.
// ---------------------------------------------------------------------------
module tb_axi_lite_arbiter_n;
  localparam int N    = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXW = 100;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- round-robin DUT ----------------
  logic [N*AW-1:0] m_araddr, m_awaddr;
  logic [N*DW-1:0] m_rdata, m_wdata;
  logic [N*SW-1:0] m_wmask;
  logic [N*2-1:0]  m_rresp, m_bresp;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]      rd_gnt, wr_gnt, rd_st, wr_st;
  logic            rd_busy, wr_busy;

  axi_lite_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  axi_lite_arbiter_n #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) dut (
    .clk(clk), .reset(reset),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s(s_if.master),
    .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .rd_busy(rd_busy), .wr_busy(wr_busy),
    .rd_state(rd_st), .wr_state(wr_st)
  );

  // ---------------- fixed-priority DUT ----------------
  logic [N*AW-1:0] fp_araddr;
  logic [N*DW-1:0] fp_rdata;
  logic [N*2-1:0]  fp_rresp, fp_bresp;
  logic [N-1:0]    fp_arvalid, fp_arready, fp_rvalid, fp_rready;
  logic [N-1:0]    fp_awready, fp_wready, fp_bvalid;
  logic [1:0]      fp_rd_gnt, fp_wr_gnt, fp_rd_st, fp_wr_st;
  logic            fp_rd_busy, fp_wr_busy;

  axi_lite_if #(.ADDR_W(AW), .DATA_W(DW)) fp_if ();

  axi_lite_arbiter_n #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) dut_fp (
    .clk(clk), .reset(reset),
    .m_araddr(fp_araddr), .m_arvalid(fp_arvalid), .m_arready(fp_arready),
    .m_rdata(fp_rdata), .m_rresp(fp_rresp), .m_rvalid(fp_rvalid), .m_rready(fp_rready),
    .m_awaddr('0), .m_awvalid('0), .m_awready(fp_awready),
    .m_wdata('0), .m_wmask('0), .m_wvalid('0), .m_wready(fp_wready),
    .m_bresp(fp_bresp), .m_bvalid(fp_bvalid), .m_bready('1),
    .s(fp_if.master),
    .rd_gnt(fp_rd_gnt), .wr_gnt(fp_wr_gnt), .rd_busy(fp_rd_busy), .wr_busy(fp_wr_busy),
    .rd_state(fp_rd_st), .wr_state(fp_wr_st)
  );

  assign fp_if.arready = 1'b1;
  assign fp_if.rvalid  = 1'b1;
  assign fp_if.rdata   = 32'hF00D_F00D;
  assign fp_if.rresp   = 2'b00;
  assign fp_if.awready = 1'b0;
  assign fp_if.wready  = 1'b0;
  assign fp_if.bresp   = 2'b00;
  assign fp_if.bvalid  = 1'b0;

  // ---------------- behavioural slave for the main DUT ----------------
  // Read data is ~address, rresp is address[5:4]; one-cycle response latency.
  logic          sl_arready_en;
  logic [1:0]    sl_bresp_cfg;
  logic          sl_rvalid, sl_bvalid, sl_got_aw, sl_got_w;
  logic [DW-1:0] sl_rdata, cap_wdata;
  logic [AW-1:0] cap_awaddr;
  logic [SW-1:0] cap_wmask;
  logic [1:0]    sl_rresp;
  logic          sl_ar_hs, sl_aw_hs, sl_w_hs;

  assign s_if.arready = sl_arready_en;
  assign s_if.rvalid  = sl_rvalid;
  assign s_if.rdata   = sl_rdata;
  assign s_if.rresp   = sl_rresp;
  assign s_if.awready = 1'b1;
  assign s_if.wready  = 1'b1;
  assign s_if.bvalid  = sl_bvalid;
  assign s_if.bresp   = sl_bresp_cfg;
  assign sl_ar_hs = s_if.arvalid & s_if.arready;
  assign sl_aw_hs = s_if.awvalid & s_if.awready;
  assign sl_w_hs  = s_if.wvalid & s_if.wready;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sl_rvalid  <= 1'b0;
      sl_rdata   <= '0;
      sl_rresp   <= '0;
      sl_bvalid  <= 1'b0;
      sl_got_aw  <= 1'b0;
      sl_got_w   <= 1'b0;
      cap_awaddr <= '0;
      cap_wdata  <= '0;
      cap_wmask  <= '0;
    end else begin
      if (sl_ar_hs) begin
        sl_rvalid <= 1'b1;
        sl_rdata  <= ~s_if.araddr;
        sl_rresp  <= s_if.araddr[5:4];
      end else if (sl_rvalid && s_if.rready) begin
        sl_rvalid <= 1'b0;
      end
      if (sl_aw_hs) begin
        sl_got_aw  <= 1'b1;
        cap_awaddr <= s_if.awaddr;
      end
      if (sl_w_hs) begin
        sl_got_w  <= 1'b1;
        cap_wdata <= s_if.wdata;
        cap_wmask <= s_if.wmask;
      end
      if (!sl_bvalid && (sl_got_aw || sl_aw_hs) && (sl_got_w || sl_w_hs)) begin
        sl_bvalid <= 1'b1;
        sl_got_aw <= 1'b0;
        sl_got_w  <= 1'b0;
      end else if (sl_bvalid && s_if.bready) begin
        sl_bvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [95:0] exp_ar_q[$];
  logic [95:0] exp_r_q[$];
  logic [95:0] exp_b_q[$];
  logic [95:0] exp_fp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ar_cyc[N];
  int r_cyc[N];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name, input int m);
    n_checks++;
    n_fail++;
    $display("FAIL %s: master %0d, got an event/timeout, expected none (cycle %0d)", name, m, cyc);
  endtask

  function automatic logic [95:0] outs_vec();
    return 96'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                s_if.arvalid, s_if.rready, s_if.awvalid, s_if.wvalid, s_if.bready,
                rd_busy, wr_busy, rd_gnt, wr_gnt, rd_st, wr_st});
  endfunction

  task automatic push_rd(input int m, input logic [AW-1:0] a);
    exp_ar_q.push_back(96'({4'(m), a}));
    exp_r_q.push_back(96'({4'(m), ~a, a[5:4]}));
  endtask

  task automatic push_b(input int m, input logic [1:0] resp, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] k);
    exp_b_q.push_back(96'({4'(m), resp, a, d, k}));
  endtask

  // Monitor: pops an expectation for every handshake the DUTs present.
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < N; i++) begin
          if (m_arvalid[i] && m_arready[i]) begin
            ar_cyc[i] = cyc;
            if (exp_ar_q.size() == 0) miss("ar_unexpected", i);
            else begin
              e = exp_ar_q.pop_front();
              chk("ar_grant", 96'({4'(i), m_araddr[i*AW +: AW]}), e);
            end
          end
          if (m_rvalid[i] && m_rready[i]) begin
            r_cyc[i] = cyc;
            chk("r_onehot", 96'($countones(m_rvalid)), 96'(1));
            if (exp_r_q.size() == 0) miss("r_unexpected", i);
            else begin
              e = exp_r_q.pop_front();
              chk("r_data", 96'({4'(i), m_rdata[i*DW +: DW], m_rresp[i*2 +: 2]}), e);
            end
          end
          if (m_bvalid[i] && m_bready[i]) begin
            chk("b_onehot", 96'($countones(m_bvalid)), 96'(1));
            if (exp_b_q.size() == 0) miss("b_unexpected", i);
            else begin
              e = exp_b_q.pop_front();
              chk("b_resp", 96'({4'(i), m_bresp[i*2 +: 2], cap_awaddr, cap_wdata, cap_wmask}), e);
            end
          end
          if (fp_arvalid[i] && fp_arready[i]) begin
            if (exp_fp_q.size() == 0) miss("fp_unexpected", i);
            else begin
              e = exp_fp_q.pop_front();
              chk("fp_grant", 96'(4'(i)), e);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rd_seq(input int m, input int n, input logic [AW-1:0] base);
    int t;
    for (int j = 0; j < n; j++) begin
      m_araddr[m*AW +: AW] = base + 32'(j * 16);
      m_arvalid[m] = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (m_arready[m]) break;
        t++;
        if (t > MAXW) begin miss("ar_timeout", m); break; end
      end
      @(posedge clk); #1;
    end
    m_arvalid[m] = 1'b0;
  endtask

  task automatic fp_rd_seq(input int m, input int n);
    int t;
    for (int j = 0; j < n; j++) begin
      fp_araddr[m*AW +: AW] = 32'h7000_0000 + 32'(m * 256 + j * 16);
      fp_arvalid[m] = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (fp_arready[m]) break;
        t++;
        if (t > MAXW) begin miss("fp_ar_timeout", m); break; end
      end
      @(posedge clk); #1;
    end
    fp_arvalid[m] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_ar_q.size() + exp_r_q.size() + exp_b_q.size() + exp_fp_q.size()) != 0
           && t < MAXW) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    chk("drain", 96'(exp_ar_q.size() + exp_r_q.size() + exp_b_q.size() + exp_fp_q.size()), 96'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected to have ended");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int c0;
    m_araddr = '0; m_arvalid = '0; m_rready = '1;
    m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wmask = '0; m_wvalid = '0; m_bready = '1;
    fp_araddr = '0; fp_arvalid = '0; fp_rready = '1;
    sl_arready_en = 1'b1;
    sl_bresp_cfg  = 2'b00;

    // Reset values
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_state", outs_vec(), 96'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_state", outs_vec(), 96'(0));

    // Round-robin fairness: 0,1,2,0,1,2 with 3-cycle reads
    push_rd(0, 32'h1000_0000); push_rd(1, 32'h2000_0000); push_rd(2, 32'h3000_0000);
    push_rd(0, 32'h1000_0010); push_rd(1, 32'h2000_0010); push_rd(2, 32'h3000_0010);
    @(posedge clk); #1;
    fork
      rd_seq(0, 2, 32'h1000_0000);
      rd_seq(1, 2, 32'h2000_0000);
      rd_seq(2, 2, 32'h3000_0000);
    join
    drain();
    chk("rr_period_01", 96'(ar_cyc[1] - ar_cyc[0]), 96'(3));
    chk("rr_period_12", 96'(ar_cyc[2] - ar_cyc[1]), 96'(3));
    chk("rr_r_latency", 96'(r_cyc[0] - ar_cyc[0]), 96'(1));

    // Fixed priority: master 0 wins until it stops requesting
    exp_fp_q.push_back(96'(0)); exp_fp_q.push_back(96'(0));
    exp_fp_q.push_back(96'(0)); exp_fp_q.push_back(96'(2));
    fork
      fp_rd_seq(0, 3);
      fp_rd_seq(2, 1);
    join
    drain();

    // Slave stall: grant locked on master 0 while master 1 waits
    sl_arready_en = 1'b0;
    push_rd(0, 32'h4000_0000); push_rd(1, 32'h5000_0000);
    fork
      rd_seq(0, 1, 32'h4000_0000);
      begin @(posedge clk); #1; rd_seq(1, 1, 32'h5000_0000); end
      begin
        @(posedge clk);
        repeat (10) begin
          @(negedge clk);
          chk("stall_lock", 96'({rd_gnt, m_arready, s_if.arvalid}), 96'({2'd0, 3'b000, 1'b1}));
        end
        @(posedge clk); #1 sl_arready_en = 1'b1;
      end
    join
    drain();
    chk("stall_next_grant", 96'(ar_cyc[1] - r_cyc[0]), 96'(2));

    // Decoupled write: W first, AW three cycles later, SLVERR response
    sl_bresp_cfg = 2'b10;
    push_b(1, 2'b10, 32'h0000_2040, 32'hDEAD_BEEF, 4'b1010);
    m_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
    m_wmask[1*SW +: SW] = 4'b1010;
    m_wvalid[1] = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (m_wready[1]) break;
      t++;
      if (t > MAXW) begin miss("w_timeout", 1); break; end
    end
    c0 = cyc;
    chk("dec_w_first", 96'({wr_gnt, m_wready}), 96'({2'd1, 3'b010}));
    @(posedge clk); #1 m_wvalid[1] = 1'b0;
    @(negedge clk);
    chk("dec_wready_c1", 96'(m_wready), 96'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("dec_wready_c2", 96'({m_wready, wr_st}), 96'({3'b000, 2'd1}));
    @(posedge clk); #1;
    m_awaddr[1*AW +: AW] = 32'h0000_2040;
    m_awvalid[1] = 1'b1;
    @(negedge clk);
    chk("dec_aw_cycle", 96'({m_awready, cyc - c0}), 96'({3'b010, 32'd3}));
    @(posedge clk); #1 m_awvalid[1] = 1'b0;
    @(negedge clk);
    chk("dec_resp_state", 96'({cyc - c0, wr_st, m_bvalid}), 96'({32'd4, 2'd2, 3'b010}));
    drain();

    // Concurrent read (master 0) and write (master 1)
    sl_bresp_cfg = 2'b00;
    push_rd(0, 32'h8000_0000);
    push_b(1, 2'b00, 32'h8000_0010, 32'h1234_5678, 4'hF);
    m_araddr[0*AW +: AW] = 32'h8000_0000;
    m_awaddr[1*AW +: AW] = 32'h8000_0010;
    m_wdata[1*DW +: DW]  = 32'h1234_5678;
    m_wmask[1*SW +: SW]  = 4'hF;
    m_arvalid[0] = 1'b1; m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("conc_valid",
        96'({s_if.arvalid, s_if.awvalid, s_if.wvalid, rd_gnt, wr_gnt,
             m_arready[0], m_awready[1], m_wready[1]}),
        96'({3'b111, 2'd0, 2'd1, 3'b111}));
    @(posedge clk); #1;
    m_arvalid[0] = 1'b0; m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0;
    drain();

    // Reset asserted in R_DATA (master 1 withholds rready)
    m_rready[1] = 1'b0;
    exp_ar_q.push_back(96'({4'(1), 32'h6000_0000}));
    rd_seq(1, 1, 32'h6000_0000);
    @(negedge clk);
    chk("pre_reset_rdata", 96'({rd_st, m_rvalid, s_if.rready}), 96'({2'd2, 3'b010, 1'b0}));
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_state", outs_vec(), 96'(0));
    @(posedge clk); #1 reset = 1'b0;
    m_rready[1] = 1'b1;

    // After reset round-robin restarts at master 0: master 1 beats master 2
    push_rd(1, 32'h9000_0000); push_rd(2, 32'hA000_0020);
    fork
      rd_seq(1, 1, 32'h9000_0000);
      rd_seq(2, 1, 32'hA000_0020);
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_n.md
# axi_lite_arbiter_n

Parametrised N-master to 1-slave AXI4-Lite arbiter with independent read and write paths. Each path has registered round-robin (or fixed-priority) grant, transaction locking and decoupled AW/W acceptance. Sits between the core's fetch/LSU/DMA masters and the shared memory/peripheral crossbar port. Supersedes the two-master fixed-priority arbiter.

## Interface
- N_MASTERS, default 2: number of masters (2..8); GW = max(1, $clog2(N_MASTERS)).
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width; strobe width DATA_W/8.
- RR_EN, default 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- clk  in  1  clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- m_araddr  in  N_MASTERS*ADDR_W  master i occupies bits [i*ADDR_W +: ADDR_W]; same slicing for all m_* vectors.
- m_arvalid / m_arready  in / out  N_MASTERS  read-address handshake.
- m_rdata  out  N_MASTERS*DATA_W  broadcast of s.rdata.
- m_rresp  out  N_MASTERS*2  broadcast of s.rresp.
- m_rvalid / m_rready  out / in  N_MASTERS  read-data handshake.
- m_awaddr  in  N_MASTERS*ADDR_W  write address.
- m_awvalid / m_awready  in / out  N_MASTERS  write-address handshake.
- m_wdata, m_wmask  in  N_MASTERS*DATA_W, N_MASTERS*DATA_W/8  write data and strobe.
- m_wvalid / m_wready  in / out  N_MASTERS  write-data handshake.
- m_bresp  out  N_MASTERS*2  broadcast of s.bresp.
- m_bvalid / m_bready  out / in  N_MASTERS  write-response handshake.
- s  axi_lite_if.master  —  downstream slave port.
- rd_gnt, wr_gnt  out  GW  currently granted master (debug).
- rd_busy, wr_busy  out  1  path not in IDLE.

## Operation
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: if any m_arvalid, compute the winner, register it in rd_gnt, update the pointer, go to R_ADDR.
  - R_ADDR: s.arvalid = m_arvalid[rd_gnt]; s.araddr = m_araddr[rd_gnt]; m_arready[rd_gnt] = s.arready. On s.arvalid && s.arready go to R_DATA.
  - R_DATA: m_rvalid[rd_gnt] = s.rvalid; s.rready = m_rready[rd_gnt]. On s.rvalid && s.rready go to R_IDLE.
- Write FSM: W_IDLE -> W_ADDR -> W_RESP -> W_IDLE.
  - W_IDLE: arbitrate on (m_awvalid | m_wvalid), register wr_gnt, clear aw_done and w_done.
  - W_ADDR: forward AW when !aw_done and W when !w_done, both from wr_gnt, each with its own handshake. aw_done/w_done set on the respective handshake. Both may complete in the same cycle or in either order. When both are done (including completion in the current cycle), go to W_RESP.
  - W_RESP: m_bvalid[wr_gnt] = s.bvalid; s.bready = m_bready[wr_gnt]. On handshake go to W_IDLE.
- Grant selection:
  - RR_EN=1: first requester scanning cyclically from rd_last+1 (resp. wr_last+1); the last-pointer is set to the winner at grant.
  - RR_EN=0: lowest requesting index.
- Non-granted masters: all ready/valid outputs 0. s.* valid outputs are 0 in IDLE and in the response states. s.araddr/awaddr/wdata/wmask are driven from the granted master at all times.
- Read and write paths are fully independent and may be active concurrently for the same or different masters.
- One outstanding transaction per path; no ID reordering.

## Timing
- Reset values:
  - FSMs in IDLE.
  - rd_gnt = wr_gnt = 0.
  - rd_last = wr_last = N_MASTERS-1, so master 0 is first.
  - aw_done = w_done = 0.
  - All valid/ready outputs 0; busy outputs 0.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k yields s.arvalid/s.awvalid high from cycle k+1.
- Minimum read occupancy is 3 cycles (IDLE, ADDR, DATA with immediate handshakes). The same holds for write when AW and W complete together.
- Back-to-back: the IDLE cycle after each response is mandatory; the next grant registers in that cycle.
- Requests arriving while a path is busy wait. AXI requires valid to be held, so no request is lost.
- Reset asserted mid-transaction: immediate return to reset values; in-flight slave responses are dropped. Reset is asynchronous assert; deassert is expected synchronous to clk.
- Masters deasserting valid before handshake violate the protocol; behaviour is undefined.

## Test plan
- Reset: assert reset mid-R_DATA with N_MASTERS=3 -> all m_*valid/ready, s.arvalid and s.rready are 0 in the same cycle; rd_busy=0, rd_gnt=0.
- Round-robin fairness: N_MASTERS=3, RR_EN=1, all three hold arvalid continuously with slave responding immediately -> grant order 0,1,2,0,1,2; each read takes 3 cycles; m_rdata matches per-master expected data.
- Fixed priority: RR_EN=0, masters 0 and 2 continuously requesting -> master 0 granted every time; master 2 granted only after master 0 drops arvalid.
- Decoupled write: granted master 1 presents W at cycle 0 and AW at cycle 3, slave ready=1 -> wready[1] pulses at cycle 0, awready[1] at cycle 3, FSM enters W_RESP at cycle 4, bvalid routed only to master 1, bresp=2'b10 passed through.
- Concurrent paths: master 0 reads 0x8000_0000 while master 1 writes 0x8000_0010 in the same cycle -> both s.arvalid and s.awvalid high the next cycle; rd_gnt=0, wr_gnt=1; both complete independently.
- Slave stall: s.arready held low for 10 cycles while another master requests -> grant stays locked; the second master's arready stays 0 throughout; it is served immediately after the first transaction's R handshake plus the IDLE cycle.
